// File: rtl/ramp_pkg.sv
// Shared types and default geometry for the inclined ramp renderer.
package ramp_pkg;

  typedef enum logic {
    RAMP_UP   = 1'b0,
    RAMP_DOWN = 1'b1
  } ramp_dir_t;

  typedef struct packed {
    logic        en;
    ramp_dir_t   dir;
    logic [10:0] hstart;
    logic [10:0] vstart;
    logic [4:0]  nsegs;
  } ramp_desc_t;

  localparam int unsigned RAMP_DESC_W = $bits(ramp_desc_t);
  localparam int unsigned TEX_ROW_W   = 5;
  localparam int unsigned TEX_COL_W   = 6;

  localparam int unsigned SEG_W_DEF    = 32;
  localparam int unsigned SEG_H_DEF    = 8;
  localparam int unsigned SEG_STEP_DEF = 3;

endpackage

// File: rtl/vga_if.sv
// VGA timing and colour bundle passed between rendering layers.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/delay.sv
// Generic resettable shift-register delay line.
module delay #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [CLK_DEL];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < CLK_DEL; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int unsigned i = 1; i < CLK_DEL; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[CLK_DEL-1];

endmodule

// File: rtl/ramp_hit.sv
// Per-ramp hit test: registers hit flag and texture row/column for one pixel.
module ramp_hit
  import ramp_pkg::*;
#(
  parameter int unsigned MAX_SEGS = 16,
  parameter int unsigned SEG_W    = SEG_W_DEF,
  parameter int unsigned SEG_H    = SEG_H_DEF,
  parameter int unsigned SEG_STEP = SEG_STEP_DEF,
  parameter int unsigned RC_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  ramp_desc_t           desc,
  input  logic [RC_W-1:0]      reveal_cnt,
  input  logic [10:0]          hcount,
  input  logic [10:0]          vcount,
  output logic                 hit,
  output logic [TEX_ROW_W-1:0] row,
  output logic [TEX_COL_W-1:0] col
);

  localparam int unsigned SHIFT = $clog2(SEG_W);

  logic [11:0]          dh;
  logic [10:0]          s;
  logic [10:0]          lim;
  logic [13:0]          off;
  logic [13:0]          top;
  logic [13:0]          bot;
  logic                 top_ok;
  logic                 v_ok;
  logic                 hit_c;
  logic [TEX_ROW_W-1:0] row_c;
  logic [TEX_COL_W-1:0] col_c;

  // top is kept 14 bits wide so negative and >2047 values are both caught by bits 13:11
  always_comb begin
    dh  = {1'b0, hcount} - {1'b0, desc.hstart};
    s   = dh[10:0] >> SHIFT;
    lim = 11'(desc.nsegs);
    if (lim > 11'(MAX_SEGS))   lim = 11'(MAX_SEGS);
    if (lim > 11'(reveal_cnt)) lim = 11'(reveal_cnt);
    off    = 14'(s) * 14'(SEG_STEP);
    top    = (desc.dir == RAMP_UP) ? 14'(desc.vstart) - off : 14'(desc.vstart) + off;
    bot    = top + 14'(SEG_H);
    top_ok = (top[13:11] == 3'b000);
    v_ok   = (14'(vcount) >= top) && (14'(vcount) <= bot);
    hit_c  = desc.en && !dh[11] && (s < lim) && top_ok && v_ok;
    row_c  = vcount[4:0] - top[4:0];
    col_c  = dh[5:0] & 6'(SEG_W - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit <= 1'b0;
      row <= '0;
      col <= '0;
    end else begin
      hit <= hit_c;
      row <= row_c;
      col <= col_c;
    end
  end

endmodule

// File: rtl/incline_ramp_renderer.sv
// Draws configurable staircase ramps over the incoming VGA stream with a
// 4-cycle pipeline and a 1-cycle-latency external texture ROM.
module incline_ramp_renderer
  import ramp_pkg::*;
#(
  parameter int unsigned NUM_RAMPS     = 4,
  parameter int unsigned MAX_SEGS      = 16,
  parameter int unsigned SEG_W         = SEG_W_DEF,
  parameter int unsigned SEG_H         = SEG_H_DEF,
  parameter int unsigned SEG_STEP      = SEG_STEP_DEF,
  parameter int unsigned REVEAL_FRAMES = 4,
  parameter logic [11:0] BLANK_RGB     = 12'h888,
  localparam int unsigned IDX_W = (NUM_RAMPS > 1) ? $clog2(NUM_RAMPS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_game,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic [RAMP_DESC_W-1:0] cfg_data,
  input  logic [11:0]            rgb_pixel,
  output logic [10:0]            pixel_addr,
  output logic                   reveal_done,
  vga_if.in                      in,
  vga_if.out                     out
);

  localparam int unsigned RC_W = $clog2(MAX_SEGS + 1);
  localparam int unsigned FC_W = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;

  ramp_desc_t shadow [NUM_RAMPS];
  ramp_desc_t active [NUM_RAMPS];

  logic [RC_W-1:0] reveal_cnt;
  logic [FC_W-1:0] frame_cnt;
  logic            frame_start;

  assign frame_start = (in.vcount == 11'd0) && (in.hcount == 11'd0);
  assign reveal_done = (reveal_cnt == RC_W'(MAX_SEGS));

  // A write landing on the commit cycle only reaches shadow; active sees it next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_RAMPS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (cfg_we && (int'(cfg_idx) < int'(NUM_RAMPS)))
        shadow[cfg_idx] <= ramp_desc_t'(cfg_data);
      if (frame_start)
        for (int unsigned i = 0; i < NUM_RAMPS; i++) active[i] <= shadow[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !start_game) begin
      frame_cnt  <= '0;
      reveal_cnt <= '0;
    end else if (frame_start) begin
      if (frame_cnt == FC_W'(REVEAL_FRAMES - 1)) begin
        frame_cnt <= '0;
        if (reveal_cnt != RC_W'(MAX_SEGS)) reveal_cnt <= reveal_cnt + 1'b1;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  logic                 hit_s1 [NUM_RAMPS];
  logic [TEX_ROW_W-1:0] row_s1 [NUM_RAMPS];
  logic [TEX_COL_W-1:0] col_s1 [NUM_RAMPS];

  for (genvar r = 0; r < NUM_RAMPS; r++) begin : g_ramp
    ramp_hit #(
      .MAX_SEGS (MAX_SEGS),
      .SEG_W    (SEG_W),
      .SEG_H    (SEG_H),
      .SEG_STEP (SEG_STEP),
      .RC_W     (RC_W)
    ) u_hit (
      .clk        (clk),
      .rst        (rst),
      .desc       (active[r]),
      .reveal_cnt (reveal_cnt),
      .hcount     (in.hcount),
      .vcount     (in.vcount),
      .hit        (hit_s1[r]),
      .row        (row_s1[r]),
      .col        (col_s1[r])
    );
  end

  logic blank_s1;

  delay #(.WIDTH(1), .CLK_DEL(1)) u_blank_d1 (
    .clk  (clk),
    .rst  (rst),
    .din  (in.hblnk | in.vblnk),
    .dout (blank_s1)
  );

  logic [37:0] dly3;
  logic [10:0] d_hcount;
  logic [10:0] d_vcount;
  logic        d_hsync;
  logic        d_hblnk;
  logic        d_vsync;
  logic        d_vblnk;
  logic [11:0] d_rgb;

  delay #(.WIDTH(38), .CLK_DEL(3)) u_vga_d3 (
    .clk  (clk),
    .rst  (rst),
    .din  ({in.hcount, in.hsync, in.hblnk, in.vcount, in.vsync, in.vblnk, in.rgb}),
    .dout (dly3)
  );

  assign {d_hcount, d_hsync, d_hblnk, d_vcount, d_vsync, d_vblnk, d_rgb} = dly3;

  logic                 sel_hit;
  logic [TEX_ROW_W-1:0] sel_row;
  logic [TEX_COL_W-1:0] sel_col;

  // Scan from the top index down so the lowest hitting ramp is assigned last.
  always_comb begin
    sel_hit = 1'b0;
    sel_row = '0;
    sel_col = '0;
    for (int unsigned i = NUM_RAMPS; i > 0; i--) begin
      if (hit_s1[i-1]) begin
        sel_hit = 1'b1;
        sel_row = row_s1[i-1];
        sel_col = col_s1[i-1];
      end
    end
  end

  logic hit_s2;
  logic hit_s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_addr <= '0;
      hit_s2     <= 1'b0;
      hit_s3     <= 1'b0;
      out.hcount <= '0;
      out.vcount <= '0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      hit_s2 <= sel_hit && !blank_s1;
      if (sel_hit && !blank_s1) pixel_addr <= {sel_row, sel_col};
      hit_s3     <= hit_s2;
      out.hcount <= d_hcount;
      out.vcount <= d_vcount;
      out.hsync  <= d_hsync;
      out.vsync  <= d_vsync;
      out.hblnk  <= d_hblnk;
      out.vblnk  <= d_vblnk;
      if (d_hblnk || d_vblnk) out.rgb <= BLANK_RGB;
      else if (hit_s3)        out.rgb <= rgb_pixel;
      else                    out.rgb <= d_rgb;
    end
  end

endmodule
